// File: rtl/fetch_stage_q_pkg.sv
// Shared definitions for the instruction-fetch stage: state codes, parameter defaults, helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package fetch_stage_q_pkg;

    // Default geometry of the fetch path (16-bit word-addressed core).
    localparam int unsigned DEF_ADDR_W   = 16;
    localparam int unsigned DEF_INST_W   = 16;
    localparam int unsigned DEF_PC_STEP  = 1;
    localparam int unsigned DEF_RESET_PC = 0;
    localparam int unsigned DEF_FQ_DEPTH = 4;

    // Fetch controller states.
    //  IDLE  : one cycle after reset release, nothing issued.
    //  RUN   : normal operation, a read may be issued every cycle.
    //  FLUSH : one bubble cycle after a redirect; any returning read is discarded.
    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_FLUSH = 2'd2
    } fetch_state_e;

    // True when a new read still fits: queued entries (after this cycle's pop)
    // plus the read already in flight must leave one free slot.
    function automatic logic fq_has_room(input int unsigned occupancy,
                                         input int unsigned depth);
        return occupancy < depth;
    endfunction

endpackage

// File: rtl/fetch_stage_q_if.sv
// Bundle of the fetch stage's memory-side and decode-side signals.
// Latency: n/a (wires only).
// Backpressure: out_ready_i is the decode-side ready; memory side has none (fixed 1-cycle read).
`timescale 1ns/1ps
interface fetch_stage_q_if
    import fetch_stage_q_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned INST_W = DEF_INST_W
);
    // Control from the pipeline
    logic              fetch_en_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;

    // Instruction memory port
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [INST_W-1:0] imem_rdata_i;

    // Decode-facing valid/ready stream
    logic              out_valid_o;
    logic              out_ready_i;
    logic [INST_W-1:0] ir_o;
    logic [ADDR_W-1:0] currpc_o;

    // Fetch stage side
    modport master (
        input  fetch_en_i,
        input  redirect_i,
        input  redirect_pc_i,
        output imem_req_o,
        output imem_addr_o,
        input  imem_rdata_i,
        output out_valid_o,
        input  out_ready_i,
        output ir_o,
        output currpc_o
    );

    // Environment side (pipeline control, memory and decode)
    modport slave (
        output fetch_en_i,
        output redirect_i,
        output redirect_pc_i,
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rdata_i,
        input  out_valid_o,
        output out_ready_i,
        input  ir_o,
        input  currpc_o
    );

endinterface

// File: rtl/fetch_stage_q_fetch_queue.sv
// Synchronous FIFO holding fetched {ir, pc} pairs; head is visible combinationally.
// Latency: push visible at head the cycle after the write edge.
// Backpressure: push while full is accepted only together with a pop; flush beats push and pop.
`timescale 1ns/1ps
module fetch_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_dat_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_dat_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);
    // DEPTH is a power of two, so the pointers wrap naturally.
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             full_w;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_w  = (cnt_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full queue can still take a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_w || do_pop);

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = cnt_q;

    // Storage array: written on accepted push, contents need no reset.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage_q.sv
// Instruction-fetch stage: owns the PC, issues 1-cycle reads and queues {ir, pc} for decode.
// Latency: 2 cycles from imem_req to out_valid; 1 instr/cycle sustained with out_ready high.
// Backpressure: stops issuing when queued + in-flight reads would overflow the queue; PC holds.
`timescale 1ns/1ps
module fetch_stage_q
    import fetch_stage_q_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned INST_W   = DEF_INST_W,
    parameter int unsigned PC_STEP  = DEF_PC_STEP,
    parameter int unsigned RESET_PC = DEF_RESET_PC,
    parameter int unsigned FQ_DEPTH = DEF_FQ_DEPTH
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    fetch_stage_q_if.master bus
);
    localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;

    typedef struct packed {
        logic [INST_W-1:0] ir;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    // Controller state
    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] tag_q;       // address of the read currently in flight
    logic              inflight_q;  // a read was issued last cycle

    // Last instruction handed to decode, shown while the queue is empty
    logic [INST_W-1:0] last_ir_q;
    logic [ADDR_W-1:0] last_pc_q;

    // Queue interface
    entry_t            fq_push_dat;
    entry_t            fq_head;
    logic [CNT_W-1:0]  fq_count;
    logic              fq_empty;
    logic              fq_push;
    logic              fq_pop;
    logic              fq_flush;

    logic              out_vld;
    logic              issue;
    int unsigned       occ_total;

    assign out_vld  = !fq_empty;

    // Redirect takes priority over everything that would touch the queue.
    assign fq_flush = bus.redirect_i;
    assign fq_pop   = out_vld && bus.out_ready_i && !bus.redirect_i;

    // Returning read lands in the queue only in RUN; in FLUSH it belongs to the
    // discarded path.
    assign fq_push        = inflight_q && (state_q == FETCH_RUN) && !bus.redirect_i;
    assign fq_push_dat.ir = bus.imem_rdata_i;
    assign fq_push_dat.pc = tag_q;

    // Slots already claimed: entries left after this cycle's pop plus the read
    // whose data arrives this cycle.
    assign occ_total = 32'(fq_count) - 32'(fq_pop) + 32'(inflight_q);

    // Issue decision is combinational so a freed slot is refilled in the same
    // cycle, which is what keeps the stream gap-free.
    assign issue = (state_q == FETCH_RUN) && bus.fetch_en_i && !bus.redirect_i &&
                   fq_has_room(occ_total, FQ_DEPTH);

    // Sequential PC, wraps silently at 2^ADDR_W.
    assign pc_d = pc_q + ADDR_W'(PC_STEP);

    assign bus.imem_req_o  = issue;
    assign bus.imem_addr_o = pc_q;
    assign bus.out_valid_o = out_vld;
    assign bus.ir_o        = out_vld ? fq_head.ir : last_ir_q;
    assign bus.currpc_o    = out_vld ? fq_head.pc : last_pc_q;

    fetch_queue #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (fq_flush),
        .push_i     (fq_push),
        .push_dat_i (fq_push_dat),
        .pop_i      (fq_pop),
        .head_dat_o (fq_head),
        .count_o    (fq_count),
        .empty_o    (fq_empty)
    );

    // Fetch controller: state, PC, in-flight tracking; redirect wins in any state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= ADDR_W'(RESET_PC);
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else if (bus.redirect_i) begin
            // No read is issued this cycle, and the one returning now is dropped
            // by the queue flush, so nothing is left in flight.
            state_q    <= FETCH_FLUSH;
            pc_q       <= bus.redirect_pc_i;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            case (state_q)
                FETCH_IDLE: begin
                    state_q <= FETCH_RUN;
                end
                FETCH_RUN: begin
                    if (issue) begin
                        tag_q <= pc_q;
                        pc_q  <= pc_d;
                    end
                end
                FETCH_FLUSH: begin
                    state_q <= FETCH_RUN;
                end
                default: begin
                    state_q <= FETCH_IDLE;
                end
            endcase
        end
    end

    // Remember the most recently accepted instruction so ir/currpc stay stable
    // (and X-free) while the queue is empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_ir_q <= '0;
            last_pc_q <= '0;
        end else if (fq_pop) begin
            last_ir_q <= fq_head.ir;
            last_pc_q <= fq_head.pc;
        end
    end

endmodule

// File: tb/tb_fetch_stage_q.sv
`timescale 1ns/1ps
module tb_fetch_stage_q;

    localparam int AW    = 16;
    localparam int IW    = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    fetch_stage_q_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

    fetch_stage_q #(
        .ADDR_W   (AW),
        .INST_W   (IW),
        .PC_STEP  (1),
        .RESET_PC (0),
        .FQ_DEPTH (DEPTH)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: mem[a] = a + 100, data one cycle after the request.
    always @(posedge clk) begin
        if (bus.imem_req_o) bus.imem_rdata_i <= bus.imem_addr_o + 16'd100;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fe, input logic rd, input logic [15:0] rpc, input logic rdy);
        bus.fetch_en_i    = fe;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc;
        bus.out_ready_i   = rdy;
    endtask

    task automatic check_outs(input string tag, input logic req, input logic [15:0] addr,
                              input logic ov, input logic [15:0] cpc, input logic [15:0] ir);
        check({tag, "_req"},    32'(bus.imem_req_o),  32'(req));
        check({tag, "_addr"},   32'(bus.imem_addr_o), 32'(addr));
        check({tag, "_ov"},     32'(bus.out_valid_o), 32'(ov));
        check({tag, "_currpc"}, 32'(bus.currpc_o),    32'(cpc));
        check({tag, "_ir"},     32'(bus.ir_o),        32'(ir));
    endtask

    // ---------------- behavioural reference model ----------------
    // Every issued read is an entry {addr, issue cycle}; it becomes visible to
    // decode two cycles after issue and leaves on pop or redirect.
    typedef struct { logic [15:0] addr; int cyc; } pend_t;
    pend_t       pend[$];
    logic [15:0] m_pc;
    logic [15:0] m_last_pc;
    logic [15:0] m_last_ir;
    logic        m_blocked;   // cycle in which no issue may happen (IDLE or FLUSH)
    int          m_cyc;

    task automatic model_reset();
        pend.delete();
        m_pc      = 16'h0000;
        m_last_pc = 16'h0000;
        m_last_ir = 16'h0000;
        m_blocked = 1'b1;
        m_cyc     = 0;
    endtask

    // Entered at a negedge: hold reset for two edges, release at a negedge.
    task automatic do_reset(input bit check_async);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        #1;
        if (check_async) check_outs("rst_async", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        #1;
        check_outs("rst_hold", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic rand_phase(input int n, input int p_fe, input int p_rd, input int p_rdy);
        for (int k = 0; k < n; k++) begin
            logic        fe, rd, rdy, exp_ov, pop_now, exp_req;
            logic [15:0] rpc, hd_ir;
            int          occ;
            fe  = ($urandom_range(0, 99) < p_fe);
            rd  = ($urandom_range(0, 99) < p_rd);
            rdy = ($urandom_range(0, 99) < p_rdy);
            case ($urandom_range(0, 3))
                0:       rpc = 16'hFFFF;
                1:       rpc = 16'hFFFE;
                default: rpc = 16'($urandom);
            endcase
            drive(fe, rd, rpc, rdy);
            #1;
            exp_ov  = (pend.size() > 0) && (pend[0].cyc + 2 <= m_cyc);
            pop_now = exp_ov && rdy && !rd;
            occ     = pend.size() - (pop_now ? 1 : 0);
            exp_req = fe && !rd && !m_blocked && (occ < DEPTH);
            check("rnd_ov",   32'(bus.out_valid_o), 32'(exp_ov));
            check("rnd_req",  32'(bus.imem_req_o),  32'(exp_req));
            check("rnd_addr", 32'(bus.imem_addr_o), 32'(m_pc));
            if (exp_ov) begin
                hd_ir = pend[0].addr + 16'd100;
                check("rnd_currpc", 32'(bus.currpc_o), 32'(pend[0].addr));
                check("rnd_ir",     32'(bus.ir_o),     32'(hd_ir));
            end else begin
                check("rnd_hold_currpc", 32'(bus.currpc_o), 32'(m_last_pc));
                check("rnd_hold_ir",     32'(bus.ir_o),     32'(m_last_ir));
            end
            if (rd) begin
                pend.delete();
                m_pc      = rpc;
                m_blocked = 1'b1;
            end else begin
                if (pop_now) begin
                    m_last_pc = pend[0].addr;
                    m_last_ir = pend[0].addr + 16'd100;
                    void'(pend.pop_front());
                end
                if (exp_req) begin
                    pend.push_back('{addr: m_pc, cyc: m_cyc});
                    m_pc = m_pc + 16'd1;
                end
                m_blocked = 1'b0;
            end
            m_cyc++;
            @(negedge clk);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic fe; logic rd; logic [15:0] rpc; logic rdy;
        logic req; logic [15:0] addr; logic ov; logic [15:0] cpc; logic [15:0] ir;
    } vec_t;
    vec_t tv[$];

    task automatic add_vec(input logic fe, input logic rd, input logic [15:0] rpc, input logic rdy,
                           input logic req, input logic [15:0] addr, input logic ov,
                           input logic [15:0] cpc, input logic [15:0] ir);
        vec_t v;
        v.fe = fe; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
        v.req = req; v.addr = addr; v.ov = ov; v.cpc = cpc; v.ir = ir;
        tv.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 1'b0);

        // Cycle 0 is the first cycle after reset release.
        //      fe    rd    rpc       rdy   | req   addr      ov    currpc    ir
        add_vec(1'b1, 1'b0, 16'h0000, 1'b0,  1'b0, 16'h0000, 1'b0, 16'h0000, 16'd0);   // 0 IDLE
        add_vec(1'b1, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h0000, 1'b0, 16'h0000, 16'd0);   // 1 first req
        add_vec(1'b1, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h0001, 1'b0, 16'h0000, 16'd0);
        add_vec(1'b1, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h0002, 1'b1, 16'h0000, 16'd100); // 3 first valid
        add_vec(1'b1, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h0003, 1'b1, 16'h0000, 16'd100);
        add_vec(1'b1, 1'b0, 16'h0000, 1'b0,  1'b0, 16'h0004, 1'b1, 16'h0000, 16'd100); // 5 full incl. in-flight
        add_vec(1'b1, 1'b0, 16'h0000, 1'b0,  1'b0, 16'h0004, 1'b1, 16'h0000, 16'd100); // 6 PC held at 4
        add_vec(1'b1, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0004, 1'b1, 16'h0000, 16'd100); // 7 drain starts
        add_vec(1'b1, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0005, 1'b1, 16'h0001, 16'd101);
        add_vec(1'b1, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0006, 1'b1, 16'h0002, 16'd102);
        add_vec(1'b1, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0007, 1'b1, 16'h0003, 16'd103);
        add_vec(1'b1, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0008, 1'b1, 16'h0004, 16'd104);
        add_vec(1'b1, 1'b0, 16'h0000, 1'b0,  1'b0, 16'h0009, 1'b1, 16'h0005, 16'd105);
        add_vec(1'b1, 1'b1, 16'h0040, 1'b0,  1'b0, 16'h0009, 1'b1, 16'h0005, 16'd105); // 13 redirect
        add_vec(1'b1, 1'b0, 16'h0000, 1'b1,  1'b0, 16'h0040, 1'b0, 16'h0004, 16'd104); // 14 FLUSH
        add_vec(1'b1, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0040, 1'b0, 16'h0004, 16'd104);
        add_vec(1'b1, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0041, 1'b0, 16'h0004, 16'd104);
        add_vec(1'b1, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0042, 1'b1, 16'h0040, 16'd164);
        add_vec(1'b1, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0043, 1'b1, 16'h0041, 16'd165);
        add_vec(1'b1, 1'b1, 16'hFFFF, 1'b1,  1'b0, 16'h0044, 1'b1, 16'h0042, 16'd166); // 19 redirect beats pop
        add_vec(1'b1, 1'b0, 16'h0000, 1'b1,  1'b0, 16'hFFFF, 1'b0, 16'h0041, 16'd165);
        add_vec(1'b1, 1'b0, 16'h0000, 1'b1,  1'b1, 16'hFFFF, 1'b0, 16'h0041, 16'd165);
        add_vec(1'b1, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0000, 1'b0, 16'h0041, 16'd165); // PC wrapped
        add_vec(1'b1, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0001, 1'b1, 16'hFFFF, 16'd99);
        add_vec(1'b1, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0002, 1'b1, 16'h0000, 16'd100);

        // Initial reset, then randomized run against the model
        do_reset(1'b0);
        rand_phase(3000, 85, 4, 65);

        // Reset asserted mid-stream takes effect immediately; table then starts from release
        do_reset(1'b1);
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].fe, tv[i].rd, tv[i].rpc, tv[i].rdy);
            #1;
            check_outs($sformatf("tv%0d", i), tv[i].req, tv[i].addr, tv[i].ov, tv[i].cpc, tv[i].ir);
            @(negedge clk);
        end

        // fetch_en dropped with one read in flight
        do_reset(1'b1);
        drive(1'b1, 1'b0, 16'h0000, 1'b1); #1;
        check_outs("fe_s0", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0000, 1'b1); #1;
        check_outs("fe_s1", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 1'b1); #1;
        check_outs("fe_s2", 1'b0, 16'h0001, 1'b0, 16'h0000, 16'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 1'b1); #1;
        check_outs("fe_s3", 1'b0, 16'h0001, 1'b1, 16'h0000, 16'd100);
        @(negedge clk);
        for (int s = 4; s < 6; s++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b1); #1;
            check_outs($sformatf("fe_s%0d", s), 1'b0, 16'h0001, 1'b0, 16'h0000, 16'd100);
            @(negedge clk);
        end
        drive(1'b1, 1'b0, 16'h0000, 1'b1); #1;
        check_outs("fe_s6", 1'b1, 16'h0001, 1'b0, 16'h0000, 16'd100);
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0000, 1'b1); #1;
        check_outs("fe_s7", 1'b1, 16'h0002, 1'b0, 16'h0000, 16'd100);
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0000, 1'b1); #1;
        check_outs("fe_s8", 1'b1, 16'h0003, 1'b1, 16'h0001, 16'd101);
        @(negedge clk);

        // Redirect in the IDLE cycle right after reset release
        do_reset(1'b1);
        drive(1'b1, 1'b1, 16'h1234, 1'b1); #1;
        check_outs("idle_r0", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0000, 1'b1); #1;
        check_outs("idle_r1", 1'b0, 16'h1234, 1'b0, 16'h0000, 16'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0000, 1'b1); #1;
        check_outs("idle_r2", 1'b1, 16'h1234, 1'b0, 16'h0000, 16'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0000, 1'b1); #1;
        check_outs("idle_r3", 1'b1, 16'h1235, 1'b0, 16'h0000, 16'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0000, 1'b1); #1;
        check_outs("idle_r4", 1'b1, 16'h1236, 1'b1, 16'h1234, 16'h1298);
        @(negedge clk);

        // Second randomized run with heavier backpressure and redirects
        do_reset(1'b1);
        rand_phase(2000, 70, 8, 40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
